// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the command-driven event counter controller:
// opcodes, controller states and the power-up prescale limit.
package counter_ctrl_pkg;

  localparam logic [2:0] OP_NOP          = 3'd0;
  localparam logic [2:0] OP_SET_PRESCALE = 3'd1;
  localparam logic [2:0] OP_SET_COMPARE  = 3'd2;
  localparam logic [2:0] OP_START        = 3'd3;
  localparam logic [2:0] OP_STOP         = 3'd4;
  localparam logic [2:0] OP_CLEAR        = 3'd5;
  localparam logic [2:0] OP_SET_MODE     = 3'd6;
  localparam logic [2:0] OP_RSVD         = 3'd7;

  localparam int PRE_DEFAULT_LIMIT = 1000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/counter_prescaler.sv
// Prescaler that counts 0..limit while enabled and flags the terminal cycle.
// Holds when disabled; clr forces the phase back to zero.
module counter_prescaler #(
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [PRE_W-1:0] limit,
  output logic             tick
);

  logic [PRE_W-1:0] cnt_q;
  logic [PRE_W-1:0] cnt_d;

  assign tick = en && (cnt_q == limit);

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + PRE_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Command-driven controller for the prescaled event counter: register file,
// run/pause/done state machine, compare logic and the valid/ready command port.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int CTR_W       = 24,
  parameter int PRE_W       = 16,
  parameter int PRE_DEFAULT = PRE_DEFAULT_LIMIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CTR_W-1:0] cmd_data,
  output logic [CTR_W-1:0] count,
  output logic             tick,
  output logic             busy,
  output logic             done
);

  ctrl_state_t      state_q, state_d;
  logic [CTR_W-1:0] count_q, count_d;
  logic [CTR_W-1:0] compare_q, compare_d;
  logic [PRE_W-1:0] limit_q, limit_d;
  logic             auto_q, auto_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  logic             accept;
  logic             run;
  logic             pre_clr;
  logic [CTR_W-1:0] count_inc;
  logic             hit;

  assign accept    = cmd_valid && ready_q;
  assign count_inc = count_q + CTR_W'(1);
  // A zero compare value means free run: no match ever fires.
  assign hit       = tick && (compare_q != '0) && (count_inc == compare_q);

  counter_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run),
    .clr   (pre_clr),
    .limit (limit_q),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Commands override the tick's own transition (e.g. STOP beats a one-shot match).
  always_comb begin
    state_d = state_q;
    if (hit && !auto_q) begin
      state_d = DONE;
    end
    if (accept) begin
      case (cmd_op)
        OP_START: if (state_q != RUN) state_d = RUN;
        OP_STOP:  if (state_q == RUN) state_d = PAUSED;
        OP_CLEAR: state_d = IDLE;
        default:  ;
      endcase
    end
  end

  always_comb begin
    run  = (state_q == RUN);
    busy = run;
  end

  always_comb begin
    count_d   = count_q;
    compare_d = compare_q;
    limit_d   = limit_q;
    auto_d    = auto_q;
    done_d    = 1'b0;
    pre_clr   = 1'b0;
    ready_d   = !accept;

    if (tick) begin
      if (hit) begin
        done_d  = 1'b1;
        count_d = auto_q ? '0 : compare_q;
      end else begin
        count_d = count_inc;
      end
    end

    if (accept) begin
      case (cmd_op)
        OP_SET_PRESCALE: begin
          limit_d = PRE_W'(cmd_data);
          pre_clr = 1'b1;
        end
        OP_SET_COMPARE: compare_d = cmd_data;
        OP_START: begin
          if (state_q == IDLE || state_q == DONE) begin
            count_d = '0;
            pre_clr = 1'b1;
          end
        end
        OP_CLEAR: begin
          count_d = '0;
          done_d  = 1'b0;
          pre_clr = 1'b1;
        end
        OP_SET_MODE: auto_d = cmd_data[0];
        OP_NOP, OP_STOP, OP_RSVD: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      compare_q <= '0;
      limit_q   <= PRE_W'(PRE_DEFAULT);
      auto_q    <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      limit_q   <= limit_d;
      auto_q    <= auto_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  assign count     = count_q;
  assign done      = done_q;
  assign cmd_ready = ready_q;

endmodule
